coin_credit_accumulator: RTL

COIN_CREDIT_ACCUMULATOR -- requirements
Module: coin_credit_accumulator

---
 rtl/coin_pkg.sv | 14 +
 rtl/change_selector.sv | 28 ++
 rtl/coin_credit_accumulator.sv | 137 +++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared types and default configuration for the coin credit accumulator.
package coin_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_CHANGE
   } state_t;

   localparam int DEF_NUM_COINS = 3;
   localparam int DEF_CREDIT_W  = 10;
   // Index 0 is the largest denomination; values strictly descending.
   localparam logic [0:DEF_NUM_COINS-1][7:0] DEF_COIN_VALUES = {8'd25, 8'd10, 8'd5};

endpackage

// File: rtl/change_selector.sv
// Greedy change picker: one-hot select of the largest denomination not exceeding credit.
module change_selector
   import coin_pkg::*;
#(
   parameter int                            NUM_COINS   = DEF_NUM_COINS,
   parameter logic [0:NUM_COINS-1][7:0]     COIN_VALUES = DEF_COIN_VALUES,
   parameter int                            CREDIT_W    = DEF_CREDIT_W
) (
   input  logic [CREDIT_W-1:0]  i_credit,
   output logic [NUM_COINS-1:0] o_sel,
   output logic [CREDIT_W-1:0]  o_value
);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      o_sel   = '0;
      o_value = '0;
      // Scan smallest to largest so the largest fitting coin is the last one written.
      for (int i = NUM_COINS - 1; i >= 0; i--) begin
         if (i_credit >= CREDIT_W'(COIN_VALUES[i])) begin
            o_sel    = '0;
            o_sel[i] = 1'b1;
            o_value  = CREDIT_W'(COIN_VALUES[i]);
         end
      end
   end

endmodule

// File: rtl/coin_credit_accumulator.sv
// Vending credit accumulator with greedy change dispensing.
// Define COIN_CREDIT_AUDIT_EN to add the outSalesTotal running sales counter.
module coin_credit_accumulator
   import coin_pkg::*;
#(
   parameter int                        NUM_COINS   = DEF_NUM_COINS,
   parameter logic [0:NUM_COINS-1][7:0] COIN_VALUES = DEF_COIN_VALUES,
   parameter int                        CREDIT_W    = DEF_CREDIT_W
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic [NUM_COINS-1:0] inCoin,
   input  logic [CREDIT_W-1:0]  inPrice,
   input  logic                 inVend,
   input  logic                 inCancel,
   input  logic                 inChangeReady,
   output logic [CREDIT_W-1:0]  outCredit,
   output logic                 outVendAck,
   output logic                 outVendNak,
   output logic                 outCoinReturn,
   output logic                 outChangeValid,
   output logic [NUM_COINS-1:0] outChangeSel,
   output logic                 outBusy
`ifdef COIN_CREDIT_AUDIT_EN
  ,output logic [15:0]          outSalesTotal
`endif
);

   state_t                r_state, w_state_nxt;
   logic [CREDIT_W-1:0]   r_credit, w_credit_nxt;
   logic                  r_vend_ack, r_vend_nak, r_coin_ret;
   logic                  w_vend_ack, w_vend_nak, w_coin_ret;

   logic                  w_coin_any, w_coin_onehot, w_coin_ok;
   logic [CREDIT_W:0]     w_coin_val, w_coin_sum;
   logic [CREDIT_W-1:0]   w_post_credit;
   logic [NUM_COINS-1:0]  w_sel;
   logic [CREDIT_W-1:0]   w_sel_value;

   change_selector #(
      .NUM_COINS   (NUM_COINS),
      .COIN_VALUES (COIN_VALUES),
      .CREDIT_W    (CREDIT_W)
   ) u_change_selector (
      .i_credit (r_credit),
      .o_sel    (w_sel),
      .o_value  (w_sel_value)
   );

   always_comb begin
      w_coin_val = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         if (inCoin[i]) w_coin_val = w_coin_val | (CREDIT_W+1)'(COIN_VALUES[i]);
      end
   end

   // The extra sum bit flags an insertion that would overflow the credit register.
   assign w_coin_any    = |inCoin;
   assign w_coin_onehot = ((inCoin & (inCoin - 1'b1)) == '0);
   assign w_coin_sum    = {1'b0, r_credit} + w_coin_val;
   assign w_coin_ok     = (r_state == ST_IDLE) && w_coin_any && w_coin_onehot &&
                          !w_coin_sum[CREDIT_W] && !inCancel;
   assign w_post_credit = w_coin_ok ? w_coin_sum[CREDIT_W-1:0] : r_credit;

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_vend_ack   = 1'b0;
      w_vend_nak   = 1'b0;
      w_coin_ret   = w_coin_any && !w_coin_ok;
      unique case (r_state)
         ST_IDLE: begin
            w_credit_nxt = w_post_credit;
            if (inCancel) begin
               if (r_credit != '0) w_state_nxt = ST_CHANGE;
            end else if (inVend) begin
               if (w_post_credit >= inPrice) begin
                  w_vend_ack   = 1'b1;
                  w_credit_nxt = w_post_credit - inPrice;
                  if (w_post_credit != inPrice) w_state_nxt = ST_CHANGE;
               end else begin
                  w_vend_nak = 1'b1;
               end
            end
         end
         ST_CHANGE: begin
            // A residue smaller than the smallest coin cannot be paid out and is dropped.
            if (w_sel == '0) begin
               w_credit_nxt = '0;
               w_state_nxt  = ST_IDLE;
            end else if (inChangeReady) begin
               w_credit_nxt = r_credit - w_sel_value;
               if (r_credit == w_sel_value) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state    <= ST_IDLE;
         r_credit   <= '0;
         r_vend_ack <= 1'b0;
         r_vend_nak <= 1'b0;
         r_coin_ret <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_credit   <= w_credit_nxt;
         r_vend_ack <= w_vend_ack;
         r_vend_nak <= w_vend_nak;
         r_coin_ret <= w_coin_ret;
      end
   end

`ifdef COIN_CREDIT_AUDIT_EN
   logic [15:0] r_sales_total;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)           r_sales_total <= '0;
      else if (w_vend_ack) r_sales_total <= r_sales_total + 16'(inPrice);
   end

   assign outSalesTotal = r_sales_total;
`endif

   // Change offer is decoded from state and credit, so reset clears it without a clock.
   assign outCredit      = r_credit;
   assign outVendAck     = r_vend_ack;
   assign outVendNak     = r_vend_nak;
   assign outCoinReturn  = r_coin_ret;
   assign outBusy        = (r_state != ST_IDLE);
   assign outChangeValid = (r_state == ST_CHANGE) && (w_sel != '0);
   assign outChangeSel   = outChangeValid ? w_sel : '0;

endmodule
